// File: rtl/div_pkg.sv
// Shared definitions for the sequential signed divider: FSM states,
// divide-by-zero quotient pattern and counter width helper.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } div_state_t;

  // All-ones quotient reported on divide by zero; sliced to the operand width.
  localparam logic [63:0] DIV_ZERO_QUOT = '1;

  // Bits needed to hold the iteration count 0..n.
  function automatic int unsigned cnt_width(input int unsigned n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/div_step.sv
// One non-restoring division iteration on an N+1-bit signed partial
// remainder P and an N-bit quotient/dividend shift register Q.
module div_step #(
  parameter int unsigned N = 32
) (
  input  logic [N:0]   p_i,
  input  logic [N-1:0] q_i,
  input  logic [N-1:0] d_i,
  output logic [N:0]   p_o,
  output logic [N-1:0] q_o
);

  logic [N:0] p_sh;

  // Shift {P,Q} left, add or subtract D by the sign of the old P, set Q[0].
  always_comb begin
    p_sh = {p_i[N-1:0], q_i[N-1]};
    if (!p_i[N]) p_o = p_sh - {1'b0, d_i};
    else         p_o = p_sh + {1'b0, d_i};
    q_o = {q_i[N-2:0], ~p_o[N]};
  end

endmodule

// File: rtl/seq_signed_divider.sv
// Multi-cycle signed divider: magnitudes are divided with non-restoring
// steps (one quotient bit per clock), signs are reapplied in a final cycle.
module seq_signed_divider
  import div_pkg::*;
#(
  parameter int unsigned N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         div_by_zero
);

  localparam int unsigned CW = cnt_width(N);

  div_state_t   state_q;
  logic [N:0]   p_q;
  logic [N-1:0] q_q;
  logic [N-1:0] d_q;
  logic         sa_q;
  logic         sb_q;
  logic [CW-1:0] cnt_q;
  logic         busy_q;
  logic         done_q;
  logic [N-1:0] quot_q;
  logic [N-1:0] rem_q;
  logic         dbz_q;

  logic [N:0]   p_d;
  logic [N-1:0] q_d;
  logic [N-1:0] a_mag;
  logic [N-1:0] b_mag;
  logic [N-1:0] rem_mag;

  div_step #(.N(N)) u_step (
    .p_i (p_q),
    .q_i (q_q),
    .d_i (d_q),
    .p_o (p_d),
    .q_o (q_d)
  );

  // Operand magnitudes (the most negative value wraps to its own pattern,
  // which is the correct unsigned magnitude) and the corrected remainder.
  // The corrected remainder always lies in [0, D) so N bits suffice.
  always_comb begin
    a_mag   = dividend[N-1] ? -dividend : dividend;
    b_mag   = divisor[N-1]  ? -divisor  : divisor;
    rem_mag = p_q[N] ? (p_q[N-1:0] + d_q) : p_q[N-1:0];
  end

  // Control FSM with datapath and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      p_q     <= '0;
      q_q     <= '0;
      d_q     <= '0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      quot_q  <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            if (divisor == '0) begin
              quot_q <= N'(DIV_ZERO_QUOT);
              rem_q  <= dividend;
              dbz_q  <= 1'b1;
              done_q <= 1'b1;
            end else begin
              q_q     <= a_mag;
              d_q     <= b_mag;
              p_q     <= '0;
              sa_q    <= dividend[N-1];
              sb_q    <= divisor[N-1];
              cnt_q   <= CW'(N);
              busy_q  <= 1'b1;
              dbz_q   <= 1'b0;
              state_q <= RUN;
            end
          end
        end
        RUN: begin
          p_q   <= p_d;
          q_q   <= q_d;
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) state_q <= FIX;
        end
        FIX: begin
          quot_q  <= (sa_q ^ sb_q) ? -q_q : q_q;
          rem_q   <= sa_q ? -rem_mag : rem_mag;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quot_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;

endmodule
